fetch_stage: RTL and testbench

//  MIPS instruction-fetch stage: owns the PC and issues requests to a 1-cycle-latency instruction memory.

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC owner, 1-cycle imem requester and DEPTH-entry queue toward IF/ID.
// Optional macro FETCH_PERF_EN adds a saturating stall counter; otherwise stall_count is tied to 0.
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4,
    output logic [31:0]      stall_count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIR} state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic             vld_p1;
    logic [WIDTH-1:0] pc_p1;
    logic [WIDTH-1:0] q_instr [DEPTH];
    logic [WIDTH-1:0] q_pc    [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    occ;
    logic [CW:0]      fill;
    logic             issue;
    logic             push;
    logic             pop;
    logic             unused_redirect_lsbs;

    // The in-flight response is counted against capacity so it always finds a free entry.
    assign fill     = {1'b0, occ} + {{CW{1'b0}}, vld_p1};
    assign issue    = (state == S_RUN) && !redirect_valid && (fill < DEPTH_C);
    assign push     = vld_p1 && !redirect_valid;
    assign pop      = id_valid && id_ready;

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign id_valid    = (occ != '0);
    assign id_instr    = q_instr[head];
    assign id_pc       = q_pc[head];
    assign id_pc_plus4 = id_pc + WIDTH'(4);

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_BOOT;
            pc     <= RESET_PC;
            vld_p1 <= 1'b0;
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
        end else begin
            vld_p1 <= issue;
            if (redirect_valid) begin
                // Flush queue and drop any in-flight response; a same-cycle pop is simply lost with the flush.
                state <= S_REDIR;
                pc    <= {redirect_pc[WIDTH-1:2], 2'b00};
                head  <= '0;
                tail  <= '0;
                occ   <= '0;
            end else begin
                if (state != S_RUN)
                    state <= S_RUN;
                if (issue)
                    pc <= pc + WIDTH'(4);
                if (push)
                    tail <= tail + PW'(1);
                if (pop)
                    head <= head + PW'(1);
                occ <= occ + CW'(push) - CW'(pop);
            end
        end
    end

    // p1: response returns one cycle after issue, tagged with the PC it was fetched from
    always_ff @(posedge clk) begin
        if (issue)
            pc_p1 <= pc;
        if (push) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= pc_p1;
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (id_valid && !id_ready)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign stall_count = stall_cnt;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance at RESET_PC=0 plus a wrap instance at RESET_PC=FFFF_FFF8.
// Cycle n below is the interval after the n-th edge; cycle 0's closing edge still samples reset low.
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hC000_0000;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid, id_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc_plus4, stall_count;

    logic        w_redirect_valid, w_ready;
    logic [31:0] w_redirect_pc;
    logic        w_imem_req, w_id_valid;
    logic [31:0] w_imem_addr, w_imem_rdata, w_id_instr, w_id_pc, w_id_pc_plus4, w_stall_count;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .stall_count(stall_count)
    );

    fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .id_valid(w_id_valid), .id_ready(w_ready), .id_instr(w_id_instr),
        .id_pc(w_id_pc), .id_pc_plus4(w_id_pc_plus4), .stall_count(w_stall_count)
    );

    // Instruction memory: data is the address XOR K, garbage when no request was made.
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? (imem_addr ^ K)   : 32'hDEAD_BEEF;
        w_imem_rdata <= w_imem_req ? (w_imem_addr ^ K) : 32'hDEAD_BEEF;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_ready = 1'b1;
        repeat (3) cyc();
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_wreq", {31'd0, w_imem_req}, 32'd0);

        cyc(); reset = 1'b1; #1;                                   // cycle 1: boot
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        cyc(); #1;                                                 // cycle 2
        chk("c2_req", {31'd0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'h0);
        chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFF8);
        cyc(); #1;                                                 // cycle 3
        chk("c3_addr", imem_addr, 32'h4);
        chk("c3_valid", {31'd0, id_valid}, 32'd0);
        chk("wrap_addr1", w_imem_addr, 32'hFFFF_FFFC);
        cyc(); #1;                                                 // cycle 4
        chk("c4_valid", {31'd0, id_valid}, 32'd1);
        chk("c4_pc", id_pc, 32'h0);
        chk("c4_instr", id_instr, K);
        chk("c4_pc4", id_pc_plus4, 32'h4);
        chk("c4_req", {31'd0, imem_req}, 32'd0);
        chk("wrap_idpc0", w_id_pc, 32'hFFFF_FFF8);
        cyc(); #1;                                                 // cycle 5
        chk("c5_pc", id_pc, 32'h4);
        chk("c5_instr", id_instr, 32'h4 ^ K);
        chk("c5_addr", imem_addr, 32'h8);
        chk("wrap_addr2", w_imem_addr, 32'h0);
        chk("wrap_idpc1", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_id_pc_plus4, 32'h0);
        cyc(); #1;                                                 // cycle 6
        chk("c6_valid", {31'd0, id_valid}, 32'd0);
        chk("c6_addr", imem_addr, 32'hC);

        cyc(); id_ready = 1'b0; #1;                                // cycle 7: stall begins
        chk("c7_pc", id_pc, 32'h8);
        chk("c7_req", {31'd0, imem_req}, 32'd0);
        for (int i = 8; i <= 11; i++) begin
            cyc(); #1;
            chk("hold_valid", {31'd0, id_valid}, 32'd1);
            chk("hold_pc", id_pc, 32'h8);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
        end

        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;  // cycle 12: redirect with full queue
        chk("stall5", stall_count, PERF ? 32'd5 : 32'd0);
        chk("c12_pc", id_pc, 32'h8);
        chk("c12_req", {31'd0, imem_req}, 32'd0);
        cyc(); redirect_valid = 1'b0; id_ready = 1'b1; #1;         // cycle 13: S_REDIR
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        chk("stall6", stall_count, PERF ? 32'd6 : 32'd0);
        cyc(); #1;                                                 // cycle 14
        chk("c14_req", {31'd0, imem_req}, 32'd1);
        chk("c14_addr", imem_addr, 32'h100);
        chk("c14_valid", {31'd0, id_valid}, 32'd0);
        cyc(); #1;                                                 // cycle 15
        chk("c15_addr", imem_addr, 32'h104);
        chk("c15_valid", {31'd0, id_valid}, 32'd0);
        cyc(); #1;                                                 // cycle 16
        chk("c16_pc", id_pc, 32'h100);
        chk("c16_instr", id_instr, 32'h100 ^ K);
        cyc(); #1;                                                 // cycle 17
        chk("c17_pc", id_pc, 32'h104);
        chk("c17_addr", imem_addr, 32'h108);
        cyc(); #1;                                                 // cycle 18
        chk("c18_valid", {31'd0, id_valid}, 32'd0);
        chk("c18_addr", imem_addr, 32'h10C);

        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;  // cycle 19: redirect with handshake
        chk("c19_valid", {31'd0, id_valid}, 32'd1);
        chk("c19_pc", id_pc, 32'h108);
        chk("c19_req", {31'd0, imem_req}, 32'd0);
        cyc(); redirect_valid = 1'b0; #1;                          // cycle 20
        chk("c20_valid", {31'd0, id_valid}, 32'd0);
        chk("c20_req", {31'd0, imem_req}, 32'd0);
        cyc(); #1;                                                 // cycle 21
        chk("c21_addr", imem_addr, 32'h200);
        chk("c21_valid", {31'd0, id_valid}, 32'd0);
        cyc(); #1;                                                 // cycle 22
        chk("c22_valid", {31'd0, id_valid}, 32'd0);
        chk("c22_addr", imem_addr, 32'h204);

        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300; #1;  // cycle 23
        chk("c23_pc", id_pc, 32'h200);
        cyc(); redirect_pc = 32'h407; #1;                          // cycle 24: redirect inside S_REDIR
        chk("c24_req", {31'd0, imem_req}, 32'd0);
        chk("c24_valid", {31'd0, id_valid}, 32'd0);
        cyc(); redirect_valid = 1'b0; #1;                          // cycle 25: S_REDIR repeats
        chk("c25_req", {31'd0, imem_req}, 32'd0);
        cyc(); #1;                                                 // cycle 26
        chk("c26_req", {31'd0, imem_req}, 32'd1);
        chk("c26_addr", imem_addr, 32'h404);

        cyc(); reset = 1'b0; #1;                                   // cycle 27: reset with request in flight
        chk("c27_addr", imem_addr, 32'h408);
        cyc(); reset = 1'b1; #1;                                   // cycle 28: boot again
        chk("rr_req", {31'd0, imem_req}, 32'd0);
        chk("rr_valid", {31'd0, id_valid}, 32'd0);
        chk("rr_stall", stall_count, 32'd0);
        cyc(); #1;                                                 // cycle 29
        chk("rr_addr", imem_addr, 32'h0);
        chk("rr_valid29", {31'd0, id_valid}, 32'd0);
        cyc(); #1;                                                 // cycle 30
        chk("rr_valid30", {31'd0, id_valid}, 32'd0);
        cyc(); #1;                                                 // cycle 31
        chk("rr_valid31", {31'd0, id_valid}, 32'd1);
        chk("rr_pc", id_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
